// File: rtl/insight_pkg.sv
// Shared types for the per-hart Insight counter consumers.
//   insight_evt_sel_t : event selection word from the hart counter interface
//   insight_evt_inc_t : per-cycle event increment, 0..3
//   INSIGHT_HALF_W    : width of one software-visible counter half
package insight_pkg;
  localparam int INSIGHT_HALF_W = 32;
  typedef logic [31:0] insight_evt_sel_t;
  typedef logic [1:0]  insight_evt_inc_t;
endpackage

// File: rtl/insight_evt_stage.sv
// Stage-1 register for Insight event consumers: registers the increment and
// flags a blank for the cycle in which the event selection changes.
// Ports:
//   clock, reset_n : clock, async active-low reset
//   evt_sel        : current event selection
//   evt_inc        : increment this cycle
//   inc_q          : registered increment
//   blank_q        : registered increment must be discarded (selection changed)
module insight_evt_stage
  import insight_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  insight_evt_sel_t evt_sel,
  input  insight_evt_inc_t evt_inc,
  output insight_evt_inc_t inc_q,
  output logic             blank_q
);

  insight_evt_sel_t sel_q;

  // sel_q resets to 0, so a nonzero selection on the first edge after reset
  // is treated as a change and blanked.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inc_q   <= '0;
      sel_q   <= '0;
      blank_q <= 1'b0;
    end else begin
      inc_q   <= evt_inc;
      sel_q   <= evt_sel;
      blank_q <= (evt_sel != sel_q);
    end
  end

endmodule

// File: rtl/insight_event_accumulator.sv
// Per-hart performance-event accumulator. Accumulates 0..3 events per cycle
// into a CNT_W-bit counter (CNT_W in 33..64), with 32-bit half writes,
// tear-free split reads through a high-half snapshot, and overflow reporting.
// Ports:
//   clock, reset_n    : clock, async active-low reset
//   evt_sel, evt_inc  : event selection and per-cycle increment
//   enable            : counting enable (0 freezes the counter)
//   wr_en/wr_hi/wr_data : half write; write wins over a same-cycle increment
//   rd_req/rd_hi      : read request; low read also snapshots the high half
//   rd_valid/rd_data  : registered read response
//   ovf, ovf_pulse    : sticky overflow flag and one-cycle wrap pulse
//   ovf_clr           : clears ovf (a same-cycle wrap wins)
module insight_event_accumulator
  import insight_pkg::*;
#(
  parameter int CNT_W = 64
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  insight_evt_sel_t          evt_sel,
  input  insight_evt_inc_t          evt_inc,
  input  logic                      enable,
  input  logic                      wr_en,
  input  logic                      wr_hi,
  input  logic [INSIGHT_HALF_W-1:0] wr_data,
  input  logic                      rd_req,
  input  logic                      rd_hi,
  output logic                      rd_valid,
  output logic [INSIGHT_HALF_W-1:0] rd_data,
  output logic                      ovf,
  output logic                      ovf_pulse,
  input  logic                      ovf_clr
);

  localparam int HI_W = CNT_W - INSIGHT_HALF_W;

  insight_evt_inc_t          inc_q;
  logic                      blank_q;
  logic [CNT_W-1:0]          cnt;
  logic [HI_W-1:0]           shadow_hi;
  logic [CNT_W:0]            sum;
  logic                      do_inc;
  logic                      carry;
  logic [INSIGHT_HALF_W-1:0] hi_ext;

  insight_evt_stage u_stage (
    .clock   (clock),
    .reset_n (reset_n),
    .evt_sel (evt_sel),
    .evt_inc (evt_inc),
    .inc_q   (inc_q),
    .blank_q (blank_q)
  );

  // One extra bit on the adder; its MSB is the wrap indicator.
  always_comb begin
    do_inc = enable && !blank_q && !wr_en;
    sum    = {1'b0, cnt} + {{(CNT_W-1){1'b0}}, inc_q};
    carry  = do_inc && sum[CNT_W];
    hi_ext = '0;
    hi_ext[HI_W-1:0] = shadow_hi;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (wr_en) begin
      if (wr_hi) cnt[CNT_W-1:INSIGHT_HALF_W] <= wr_data[HI_W-1:0];
      else       cnt[INSIGHT_HALF_W-1:0]     <= wr_data;
    end else if (do_inc) begin
      cnt <= sum[CNT_W-1:0];
    end
  end

  // Reads sample the pre-update counter; the low read freezes the high half
  // so a following high read pairs with it even if the counter carried.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      shadow_hi <= '0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) begin
        if (rd_hi) begin
          rd_data <= hi_ext;
        end else begin
          rd_data   <= cnt[INSIGHT_HALF_W-1:0];
          shadow_hi <= cnt[CNT_W-1:INSIGHT_HALF_W];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ovf       <= 1'b0;
      ovf_pulse <= 1'b0;
    end else begin
      ovf_pulse <= carry;
      if (carry)        ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_insight_event_accumulator.sv
module tb_insight_event_accumulator;
  import insight_pkg::*;

  localparam int CNT_W = 64;
  localparam logic [CNT_W-1:0] MAXV = '1;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] evt_sel = '0;
  logic [1:0]  evt_inc = '0;
  logic        enable = 1'b0;
  logic        wr_en = 1'b0;
  logic        wr_hi = 1'b0;
  logic [31:0] wr_data = '0;
  logic        rd_req = 1'b0;
  logic        rd_hi = 1'b0;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        ovf;
  logic        ovf_pulse;
  logic        ovf_clr = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  insight_event_accumulator #(.CNT_W(CNT_W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .evt_sel   (evt_sel),
    .evt_inc   (evt_inc),
    .enable    (enable),
    .wr_en     (wr_en),
    .wr_hi     (wr_hi),
    .wr_data   (wr_data),
    .rd_req    (rd_req),
    .rd_hi     (rd_hi),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .ovf       (ovf),
    .ovf_pulse (ovf_pulse),
    .ovf_clr   (ovf_clr)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the counter as a number. An increment offered in a
  // cycle counts one edge later unless the selection changed in that cycle;
  // it is then dropped if counting is inhibited or a write lands instead.
  logic [CNT_W-1:0] m_cnt;
  logic [CNT_W-1:0] m_pend;
  logic [31:0]      m_prev_sel;
  logic [31:0]      m_shadow;
  logic             exp_rd_valid;
  logic [31:0]      exp_rd_data;
  logic             exp_ovf;
  logic             exp_pulse;
  logic             wrapped;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_cnt = '0; m_pend = '0; m_prev_sel = '0; m_shadow = '0;
      exp_rd_valid = 1'b0; exp_rd_data = '0; exp_ovf = 1'b0; exp_pulse = 1'b0;
    end else begin
      exp_rd_valid = rd_req;
      if (rd_req) begin
        if (!rd_hi) begin
          exp_rd_data = m_cnt[31:0];
          m_shadow    = 32'(m_cnt / (64'd1 << 32));
        end else begin
          exp_rd_data = m_shadow;
        end
      end
      wrapped = 1'b0;
      if (wr_en) begin
        if (wr_hi) m_cnt = (m_cnt % (64'd1 << 32)) + (CNT_W'(wr_data) << 32);
        else       m_cnt = (m_cnt - (m_cnt % (64'd1 << 32))) + CNT_W'(wr_data);
      end else if (enable) begin
        if (MAXV - m_cnt < m_pend) begin
          wrapped = 1'b1;
          m_cnt   = m_pend - (MAXV - m_cnt) - 1;
        end else begin
          m_cnt = m_cnt + m_pend;
        end
      end
      exp_pulse = wrapped;
      if (wrapped)      exp_ovf = 1'b1;
      else if (ovf_clr) exp_ovf = 1'b0;
      m_pend     = (evt_sel == m_prev_sel) ? CNT_W'(evt_inc) : '0;
      m_prev_sel = evt_sel;
    end
  end

  always @(negedge clock) begin
    chk("rd_valid", 64'(rd_valid), 64'(exp_rd_valid));
    chk("rd_data", 64'(rd_data), 64'(exp_rd_data));
    chk("ovf", 64'(ovf), 64'(exp_ovf));
    chk("ovf_pulse", 64'(ovf_pulse), 64'(exp_pulse));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wr(input logic hi, input logic [31:0] d);
    wr_en = 1'b1; wr_hi = hi; wr_data = d;
    cyc(1);
    wr_en = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic hi, input logic [31:0] exp);
    rd_req = 1'b1; rd_hi = hi;
    cyc(1);
    rd_req = 1'b0;
    chk(tag, 64'(rd_data), 64'(exp));
  endtask

  initial begin
    #12;
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_pulse", 64'(ovf_pulse), 64'd0);
    cyc(1);
    reset_n = 1'b1;

    // Steady count with blanked first cycle
    evt_sel = 32'd5; evt_inc = 2'd3; enable = 1'b1;
    cyc(10);
    evt_inc = 2'd0;
    cyc(2);
    rd_chk("s1_cnt27", 1'b0, 32'd27);

    // Wrap from all-ones - 1
    wr(1'b0, 32'hFFFF_FFFE);
    wr(1'b1, 32'hFFFF_FFFF);
    evt_inc = 2'd3; cyc(1);
    evt_inc = 2'd0; cyc(1);
    chk("s2_pulse", 64'(ovf_pulse), 64'd1);
    chk("s2_ovf", 64'(ovf), 64'd1);
    cyc(1);
    chk("s2_pulse_gone", 64'(ovf_pulse), 64'd0);
    chk("s2_ovf_sticky", 64'(ovf), 64'd1);
    ovf_clr = 1'b1; cyc(1); ovf_clr = 1'b0;
    chk("s2_ovf_clr", 64'(ovf), 64'd0);
    rd_chk("s2_cnt1", 1'b0, 32'd1);

    // Back-to-back selection changes
    wr(1'b0, 32'd0);
    evt_inc = 2'd1;
    evt_sel = 32'd6; cyc(1);
    evt_sel = 32'd7; cyc(1);
    cyc(4);
    evt_inc = 2'd0; cyc(2);
    rd_chk("s3_cnt4", 1'b0, 32'd4);

    // Tear-free split read across a carry into the high half
    wr(1'b1, 32'd1);
    wr(1'b0, 32'hFFFF_FFFF);
    evt_inc = 2'd1; cyc(1);
    evt_inc = 2'd0;
    rd_chk("s4_lo", 1'b0, 32'hFFFF_FFFF);
    rd_chk("s4_hi", 1'b1, 32'd1);
    rd_chk("s4_lo2", 1'b0, 32'd0);
    rd_chk("s4_hi2", 1'b1, 32'd2);

    // Write beats increment; enable=0 freezes
    wr(1'b1, 32'd0);
    evt_inc = 2'd2; cyc(1);
    evt_inc = 2'd0;
    wr(1'b0, 32'd100);
    enable = 1'b0; evt_inc = 2'd3; cyc(5);
    evt_inc = 2'd0; cyc(2);
    enable = 1'b1;
    rd_chk("s5_cnt100", 1'b0, 32'd100);
    rd_chk("s5_hi0", 1'b1, 32'd0);

    // Asynchronous reset mid-stream
    wr(1'b1, 32'hFFFF_FFFF);
    wr(1'b0, 32'hFFFF_FFFF);
    evt_inc = 2'd1; cyc(1);
    evt_inc = 2'd0; cyc(1);
    wr(1'b1, 32'd0);
    wr(1'b0, 32'h1234);
    rd_chk("s6_pre", 1'b0, 32'h1234);
    chk("s6_ovf_pre", 64'(ovf), 64'd1);
    rd_req = 1'b1; rd_hi = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("s6_rd_data", 64'(rd_data), 64'd0);
    chk("s6_rd_valid", 64'(rd_valid), 64'd0);
    chk("s6_ovf", 64'(ovf), 64'd0);
    chk("s6_pulse", 64'(ovf_pulse), 64'd0);
    @(negedge clock);
    chk("s6_rd_valid_next", 64'(rd_valid), 64'd0);
    rd_req = 1'b0;
    reset_n = 1'b1;
    evt_sel = 32'd0;
    cyc(1);
    rd_chk("s6_cnt_clr", 1'b0, 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 4) == 0) evt_sel = $urandom_range(0, 3);
      evt_inc = 2'($urandom_range(0, 3));
      enable  = ($urandom_range(0, 9) != 0);
      wr_en   = ($urandom_range(0, 19) == 0);
      wr_hi   = 1'($urandom_range(0, 1));
      wr_data = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : $urandom;
      rd_req  = 1'($urandom_range(0, 1));
      rd_hi   = 1'($urandom_range(0, 1));
      ovf_clr = ($urandom_range(0, 9) == 0);
      cyc(1);
    end
    wr_en = 1'b0; rd_req = 1'b0; ovf_clr = 1'b0; evt_inc = 2'd0;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
